// File: rtl/input_seq_pkg.sv
// input_seq_pkg
// Shared definitions for the operand/opcode input sequencer: the 2-bit state
// encoding (also driven out for display) and the default parameter values.
package input_seq_pkg;

  localparam int unsigned DEF_WIDTH           = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_OPCODE = 2'd2,
    S_RESULT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/input_sequencer_btn_debounce.sv
// btn_debounce
// Two-flop synchronizer, debounce down-counter and press-edge pulse for one
// raw pushbutton.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   btn_raw  : raw bouncing button, active-high
//   press    : one-cycle pulse on an accepted 0->1 level change
module btn_debounce
  import input_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned   CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fill_q, fill_d;
  logic          arm_q, arm_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = RELOAD;
    press_d = 1'b0;
    // fill_q[1] marks the synchronizer as holding post-reset samples. A button
    // still held from before reset never shows a low sample, so it stays
    // unarmed until it has been released.
    arm_d   = arm_q | (fill_q[1] & ~sync2_q);
    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync2_q;
        press_d = sync2_q & arm_q;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= RELOAD;
      fill_q  <= 2'b00;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      arm_q   <= arm_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/input_sequencer.sv
// input_sequencer
// Steps the user through entering operand 1, operand 2 and the opcode from
// the slide switches, using debounced enter/back buttons.
//
//   state    | meaning
//   S_OP1    | waiting for operand 1
//   S_OP2    | waiting for operand 2
//   S_OPCODE | waiting for the opcode
//   S_RESULT | result displayed
//
//   clk          : system clock
//   RST_BTN_n    : synchronous active-low reset
//   btn_enter    : raw enter button
//   btn_back     : raw back button
//   switches     : raw slide switches
//   val          : registered switch snapshot for the operand/opcode bank
//   load_op1     : one-cycle load strobe, operand 1
//   load_op2     : one-cycle load strobe, operand 2
//   load_opcode  : one-cycle load strobe, opcode
//   state        : current state code
//   show_result  : high while in S_RESULT
module input_sequencer
  import input_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WIDTH           = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             RST_BTN_n,
  input  logic             btn_enter,
  input  logic             btn_back,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] val,
  output logic             load_op1,
  output logic             load_op2,
  output logic             load_opcode,
  output logic [1:0]       state,
  output logic             show_result
);

  logic             enter_p, back_p;
  logic [WIDTH-1:0] sw_sync1_q, sw_sync2_q;
  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             ld_op1_q, ld_op1_d;
  logic             ld_op2_q, ld_op2_d;
  logic             ld_opc_q, ld_opc_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .rst_n   (RST_BTN_n),
    .btn_raw (btn_enter),
    .press   (enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk     (clk),
    .rst_n   (RST_BTN_n),
    .btn_raw (btn_back),
    .press   (back_p)
  );

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    ld_op1_d = 1'b0;
    ld_op2_d = 1'b0;
    ld_opc_d = 1'b0;
    // Simultaneous enter and back is ambiguous, so neither is acted on.
    if (enter_p && !back_p) begin
      case (state_q)
        S_OP1:    begin state_d = S_OP2;    ld_op1_d = 1'b1; val_d = sw_sync2_q; end
        S_OP2:    begin state_d = S_OPCODE; ld_op2_d = 1'b1; val_d = sw_sync2_q; end
        S_OPCODE: begin state_d = S_RESULT; ld_opc_d = 1'b1; val_d = sw_sync2_q; end
        S_RESULT: state_d = S_OP1;
        default:  state_d = S_OP1;
      endcase
    end else if (back_p && !enter_p) begin
      case (state_q)
        S_OP2:    state_d = S_OP1;
        S_OPCODE: state_d = S_OP2;
        S_RESULT: state_d = S_OPCODE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_BTN_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      state_q    <= S_OP1;
      val_q      <= '0;
      ld_op1_q   <= 1'b0;
      ld_op2_q   <= 1'b0;
      ld_opc_q   <= 1'b0;
    end else begin
      sw_sync1_q <= switches;
      sw_sync2_q <= sw_sync1_q;
      state_q    <= state_d;
      val_q      <= val_d;
      ld_op1_q   <= ld_op1_d;
      ld_op2_q   <= ld_op2_d;
      ld_opc_q   <= ld_opc_d;
    end
  end

  assign val         = val_q;
  assign load_op1    = ld_op1_q;
  assign load_op2    = ld_op2_q;
  assign load_opcode = ld_opc_q;
  assign state       = state_q;
  assign show_result = (state_q == S_RESULT);

endmodule

// File: tb/tb_input_sequencer.sv
module tb_input_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_enter = 1'b0;
  logic        btn_back = 1'b0;
  logic [15:0] switches = 16'h0000;
  logic [15:0] val;
  logic        load_op1, load_op2, load_opcode, show_result;
  logic [1:0]  state;

  int tests_run = 0;
  int tests_failed = 0;

  int n_op1 = 0, n_op2 = 0, n_opc = 0;
  int multi_err = 0, val_err = 0;
  logic [15:0] prev_val = 16'h0000;
  logic        rst_at_edge = 1'b0;

  input_sequencer #(.DEBOUNCE_CYCLES(4), .WIDTH(16)) dut (
    .clk         (clk),
    .RST_BTN_n   (rst_n),
    .btn_enter   (btn_enter),
    .btn_back    (btn_back),
    .switches    (switches),
    .val         (val),
    .load_op1    (load_op1),
    .load_op2    (load_op2),
    .load_opcode (load_opcode),
    .state       (state),
    .show_result (show_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge <= rst_n;

  // Pulse counting and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_op1 === 1'b1) n_op1++;
    if (load_op2 === 1'b1) n_op2++;
    if (load_opcode === 1'b1) n_opc++;
    if (int'(load_op1) + int'(load_op2) + int'(load_opcode) > 1) multi_err++;
    if (rst_at_edge && (val !== prev_val) && !(load_op1 | load_op2 | load_opcode)) val_err++;
    prev_val = val;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_op1 = 0;
    n_op2 = 0;
    n_opc = 0;
  endtask

  task automatic press_enter(input logic [15:0] sw);
    switches  = sw;
    btn_enter = 1'b1;
    tick(12);
    btn_enter = 1'b0;
    tick(12);
  endtask

  task automatic press_back();
    btn_back = 1'b1;
    tick(12);
    btn_back = 1'b0;
    tick(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_enter = 1'b0; btn_back = 1'b0; switches = 16'h0000;
    tick(3);
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests_run++;
    if (val !== 16'h0000) begin tests_failed++; $display("FAIL reset_val: got %h expected 0000", val); end
    tests_run++;
    if ({load_op1, load_op2, load_opcode} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_loads: got %b expected 000", {load_op1, load_op2, load_opcode});
    end
    tests_run++;
    if (show_result !== 1'b0) begin tests_failed++; $display("FAIL reset_show: got %b expected 0", show_result); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    switches  = 16'h0012;
    btn_enter = 1'b1;
    tick(6);
    tests_run++;
    if (load_op1 !== 1'b0) begin tests_failed++; $display("FAIL op1_early: got %b expected 0", load_op1); end
    tick(1);
    tests_run++;
    if (load_op1 !== 1'b1) begin tests_failed++; $display("FAIL op1_strobe: got %b expected 1", load_op1); end
    tests_run++;
    if (val !== 16'h0012) begin tests_failed++; $display("FAIL op1_val: got %h expected 0012", val); end
    tests_run++;
    if (state !== 2'd1) begin tests_failed++; $display("FAIL op1_state: got %0d expected 1", state); end
    tick(1);
    tests_run++;
    if (load_op1 !== 1'b0) begin tests_failed++; $display("FAIL op1_one_cycle: got %b expected 0", load_op1); end
    btn_enter = 1'b0;
    tick(12);
    clear_counts();
    press_enter(16'h0034);
    tests_run++;
    if (n_op2 !== 1 || n_op1 !== 0 || n_opc !== 0) begin
      tests_failed++; $display("FAIL op2_pulses: got %0d/%0d/%0d expected 0/1/0", n_op1, n_op2, n_opc);
    end
    tests_run++;
    if (val !== 16'h0034 || state !== 2'd2) begin
      tests_failed++; $display("FAIL op2_val_state: got %h/%0d expected 0034/2", val, state);
    end
    clear_counts();
    press_enter(16'h0003);
    tests_run++;
    if (n_opc !== 1 || n_op1 !== 0 || n_op2 !== 0) begin
      tests_failed++; $display("FAIL opc_pulses: got %0d/%0d/%0d expected 0/0/1", n_op1, n_op2, n_opc);
    end
    tests_run++;
    if (val !== 16'h0003 || state !== 2'd3 || show_result !== 1'b1) begin
      tests_failed++; $display("FAIL opc_result: got %h/%0d/%b expected 0003/3/1", val, state, show_result);
    end
  endtask

  task automatic test_result_enter();
    clear_counts();
    press_enter(16'h0044);
    tests_run++;
    if (state !== 2'd0 || show_result !== 1'b0) begin
      tests_failed++; $display("FAIL result_enter_state: got %0d/%b expected 0/0", state, show_result);
    end
    tests_run++;
    if (n_op1 + n_op2 + n_opc !== 0 || val !== 16'h0003) begin
      tests_failed++; $display("FAIL result_enter_nostrobe: got %0d strobes val %h expected 0 val 0003",
                               n_op1 + n_op2 + n_opc, val);
    end
  endtask

  task automatic test_bounce();
    switches = 16'h0055;
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      btn_enter = ((i % 4) < 2);
      tick(1);
    end
    tests_run++;
    if (n_op1 !== 0 || state !== 2'd0) begin
      tests_failed++; $display("FAIL bounce_no_pulse: got %0d pulses state %0d expected 0 state 0", n_op1, state);
    end
    btn_enter = 1'b1;
    tick(12);
    btn_enter = 1'b0;
    tick(12);
    tests_run++;
    if (n_op1 !== 1 || val !== 16'h0055 || state !== 2'd1) begin
      tests_failed++; $display("FAIL bounce_one_pulse: got %0d/%h/%0d expected 1/0055/1", n_op1, val, state);
    end
  endtask

  task automatic test_back();
    press_enter(16'h0011);
    clear_counts();
    press_back();
    tests_run++;
    if (state !== 2'd1 || n_op1 + n_op2 + n_opc !== 0) begin
      tests_failed++; $display("FAIL back_opcode: got state %0d strobes %0d expected 1/0", state, n_op1 + n_op2 + n_opc);
    end
    clear_counts();
    press_enter(16'h00FF);
    tests_run++;
    if (n_op2 !== 1 || val !== 16'h00FF || state !== 2'd2) begin
      tests_failed++; $display("FAIL back_reenter: got %0d/%h/%0d expected 1/00ff/2", n_op2, val, state);
    end
  endtask

  task automatic test_simultaneous();
    press_back();
    clear_counts();
    switches  = 16'h0BCD;
    btn_enter = 1'b1;
    btn_back  = 1'b1;
    tick(12);
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    tick(12);
    tests_run++;
    if (state !== 2'd1 || n_op1 + n_op2 + n_opc !== 0 || val !== 16'h00FF) begin
      tests_failed++; $display("FAIL simultaneous: got state %0d strobes %0d val %h expected 1/0/00ff",
                               state, n_op1 + n_op2 + n_opc, val);
    end
  endtask

  task automatic test_reset_strobe();
    switches  = 16'h0AAA;
    btn_enter = 1'b1;
    tick(7);
    tests_run++;
    if (load_op2 !== 1'b1 || val !== 16'h0AAA) begin
      tests_failed++; $display("FAIL rst_pre_strobe: got %b/%h expected 1/0aaa", load_op2, val);
    end
    rst_n = 1'b0;
    tick(1);
    tests_run++;
    if (state !== 2'd0 || val !== 16'h0000 || {load_op1, load_op2, load_opcode} !== 3'b000) begin
      tests_failed++; $display("FAIL rst_abort: got %0d/%h/%b expected 0/0000/000",
                               state, val, {load_op1, load_op2, load_opcode});
    end
    tick(2);
    rst_n = 1'b1;
    clear_counts();
    tick(20);
    tests_run++;
    if (n_op1 + n_op2 + n_opc !== 0 || state !== 2'd0) begin
      tests_failed++; $display("FAIL held_through_reset: got %0d strobes state %0d expected 0/0",
                               n_op1 + n_op2 + n_opc, state);
    end
    btn_enter = 1'b0;
    tick(12);
    tests_run++;
    if (n_op1 + n_op2 + n_opc !== 0) begin
      tests_failed++; $display("FAIL release_after_reset: got %0d strobes expected 0", n_op1 + n_op2 + n_opc);
    end
  endtask

  task automatic test_hold();
    clear_counts();
    switches  = 16'h0777;
    btn_enter = 1'b1;
    tick(100);
    tests_run++;
    if (n_op1 !== 1 || n_op2 !== 0 || n_opc !== 0) begin
      tests_failed++; $display("FAIL hold_pulses: got %0d/%0d/%0d expected 1/0/0", n_op1, n_op2, n_opc);
    end
    tests_run++;
    if (val !== 16'h0777 || state !== 2'd1) begin
      tests_failed++; $display("FAIL hold_val_state: got %h/%0d expected 0777/1", val, state);
    end
    btn_enter = 1'b0;
    tick(12);
    press_enter(16'h0001);
    press_enter(16'h0002);
    tests_run++;
    if (state !== 2'd3 || show_result !== 1'b1) begin
      tests_failed++; $display("FAIL reach_result: got %0d/%b expected 3/1", state, show_result);
    end
    clear_counts();
    press_enter(16'h0009);
    tests_run++;
    if (state !== 2'd0 || show_result !== 1'b0 || n_op1 + n_op2 + n_opc !== 0 || val !== 16'h0002) begin
      tests_failed++; $display("FAIL result_wrap: got %0d/%b/%0d/%h expected 0/0/0/0002",
                               state, show_result, n_op1 + n_op2 + n_opc, val);
    end
  endtask

  task automatic test_invariants();
    tests_run++;
    if (multi_err !== 0) begin tests_failed++; $display("FAIL one_hot_loads: got %0d violations expected 0", multi_err); end
    tests_run++;
    if (val_err !== 0) begin tests_failed++; $display("FAIL val_hold: got %0d changes without strobe expected 0", val_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_result_enter();
    test_bounce();
    test_back();
    test_simultaneous();
    test_reset_strobe();
    test_hold();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles before a button level change is accepted.
REQ-002 Parameter WIDTH, default 16, operand/opcode data width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 RST_BTN_n  input  1  reset, synchronous, active-low.
REQ-005 btn_enter  input  1  raw, unsynchronized, bouncing "enter" pushbutton, active-high.
REQ-006 btn_back  input  1  raw, unsynchronized, bouncing "back" pushbutton, active-high.
REQ-007 switches  input  WIDTH  raw slide-switch value.
REQ-008 val  output  WIDTH  registered switch snapshot presented to the downstream operand/opcode bank.
REQ-009 load_op1  output  1  one-cycle load strobe for operand 1 register.
REQ-010 load_op2  output  1  one-cycle load strobe for operand 2 register.
REQ-011 load_opcode  output  1  one-cycle load strobe for ALU control register.
REQ-012 state  output  2  current FSM state code, for display.
REQ-013 show_result  output  1  high while in S_RESULT.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: accepted level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-015 Each debouncer SHALL emit a one-cycle press pulse on the accepted 0->1 transition only; holding the button SHALL NOT repeat.
REQ-016 FSM states with codes: S_OP1=0, S_OP2=1, S_OPCODE=2, S_RESULT=3.
REQ-017 Enter pulse in cycle N, state S_OP1: in cycle N+1 load_op1=1, val=switches_sync sampled in cycle N, state=S_OP2.
REQ-018 Enter in S_OP2: load_op2 strobe, next S_OPCODE; enter in S_OPCODE: load_opcode strobe, next S_RESULT; same N+1 timing as REQ-017.
REQ-019 Enter in S_RESULT: next S_OP1, no strobe.
REQ-020 Back pulse: S_OP2->S_OP1, S_OPCODE->S_OP2, S_RESULT->S_OPCODE, S_OP1 stays; no strobe.
REQ-021 Enter and back pulses in the same cycle: both ignored, state unchanged, no strobe.
REQ-022 At most one load_* SHALL be high in any cycle; each high for exactly one cycle per accepted enter.
REQ-023 val SHALL change only in the cycle a strobe is issued and hold otherwise.
REQ-024 Debounce counter SHALL saturate/restart cleanly; no press pulse from bounces shorter than DEBOUNCE_CYCLES.

Reset
REQ-025 While RST_BTN_n=0 at a clock edge: state=S_OP1, val=0, all load_*=0, show_result=0, synchronizers and debounce counters cleared, debounced levels=0.
REQ-026 A button held through reset release SHALL NOT produce a press pulse until released and re-pressed.
REQ-027 Reset asserted mid-debounce or during a strobe cycle SHALL abort it; no strobe in the cycle after reset.

Structure
REQ-028 Shared package input_seq_pkg SHALL hold the state enum (2-bit) and default WIDTH/DEBOUNCE_CYCLES constants.
REQ-029 One sub-module btn_debounce (synchronizer + counter + edge pulse), instantiated once per button.
REQ-030 FSM, strobe generation and val register SHALL reside in input_sequencer.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, then three clean enter presses with switches=0x0012, 0x0034, 0x0003 -> load_op1/op2/opcode one pulse each with val=0x0012/0x0034/0x0003; state 0->1->2->3; show_result=1.
REQ-032 Enter toggling with 2-cycle bounce intervals for 10 cycles, then stable high -> exactly one load_op1 pulse.
REQ-033 In S_OPCODE press back -> state=1, no strobe; press enter with switches=0x00FF -> load_op2, val=0x00FF.
REQ-034 Enter and back pulses in the same cycle in S_OP2 -> state stays 1, no strobe.
REQ-035 Assert RST_BTN_n=0 in the strobe cycle while in S_OP2 -> next cycle state=0, val=0, all strobes 0; enter held across reset gives no pulse until re-pressed.
REQ-036 Enter held 100 cycles in S_OP1 -> one load_op1 only; S_RESULT + enter -> state=0, no strobe.
